// File: rtl/timer_ctrl.sv
// Control and sequencing for the two 8051 timer/counter datapaths: owns TMOD, TCON[7:4],
// TH0/TL0/TH1/TL1, the machine-cycle tick, pin qualification and overflow flags.
module timer_ctrl #(
   parameter int CLK_PER_MC = 12
) (
   input  logic       clk,
   input  logic       rst,

   input  logic [7:0] sfr_addr,
   input  logic       sfr_we,
   input  logic [7:0] sfr_wdata,
   output logic [7:0] sfr_rdata,

   input  logic       t0_pin,
   input  logic       t1_pin,
   input  logic       int0_n,
   input  logic       int1_n,

   input  logic       tf0_clr,
   input  logic       tf1_clr,
   output logic       tf0,
   output logic       tf1,

   output logic       t0_cnt_sig,
   output logic       t0_t_s,
   output logic [3:0] t0_tmod,
   output logic [7:0] t0_th,
   output logic [7:0] t0_tl,
   input  logic [7:0] t0_th_nxt,
   input  logic [7:0] t0_tl_nxt,
   input  logic       t0_t_o,

   output logic       t1_cnt_sig,
   output logic       t1_t_s,
   output logic [3:0] t1_tmod,
   output logic [7:0] t1_th,
   output logic [7:0] t1_tl,
   input  logic [7:0] t1_th_nxt,
   input  logic [7:0] t1_tl_nxt,
   input  logic       t1_t_o
);

   localparam logic [7:0] ADDR_TCON = 8'h88;
   localparam logic [7:0] ADDR_TMOD = 8'h89;
   localparam logic [7:0] ADDR_TL0  = 8'h8A;
   localparam logic [7:0] ADDR_TL1  = 8'h8B;
   localparam logic [7:0] ADDR_TH0  = 8'h8C;
   localparam logic [7:0] ADDR_TH1  = 8'h8D;

   localparam int PW = (CLK_PER_MC > 2) ? $clog2(CLK_PER_MC) : 1;
   localparam logic [PW-1:0] PRESC_LAST     = PW'(CLK_PER_MC - 1);
   localparam logic [PW-1:0] PRESC_PRE_LAST = PW'(CLK_PER_MC - 2);

   logic [PW-1:0] presc;
   logic          tick;

   logic [7:0] tmod;
   logic       tr0;
   logic       tr1;
   logic [7:0] th0;
   logic [7:0] tl0;
   logic [7:0] th1;
   logic [7:0] tl1;

   // Bit order of the synchronizer vectors: {int1_n, int0_n, t1_pin, t0_pin}.
   logic [3:0] pin_raw;
   logic [3:0] sync1;
   logic [3:0] sync2;
   logic [1:0] t_prev;
   logic [1:0] t_fall;
   logic [1:0] pend;

   logic run0;
   logic run1;

   logic wr_tcon;
   logic wr_tmod;
   logic wr_tl0;
   logic wr_tl1;
   logic wr_th0;
   logic wr_th1;

   // ---------------------------------------------------------------------------------
   // Machine-cycle tick: registered one cycle ahead of the wrap so it is high exactly
   // in the cycle where the prescaler sits at its last value.
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
         tick  <= (presc == PRESC_PRE_LAST);
      end
   end

   // ---------------------------------------------------------------------------------
   // Pin synchronizers and Tx falling-edge capture
   // ---------------------------------------------------------------------------------
   assign pin_raw = {int1_n, int0_n, t1_pin, t0_pin};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 4'hF;
         sync2  <= 4'hF;
         t_prev <= 2'b11;
      end else begin
         sync1  <= pin_raw;
         sync2  <= sync1;
         t_prev <= sync2[1:0];
      end
   end

   assign t_fall = t_prev & ~sync2[1:0];

   // A new edge wins over the tick clear, so an edge seen in a tick cycle waits for the next tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 2'b00;
      end else begin
         pend <= t_fall | (pend & {2{~tick}});
      end
   end

   // ---------------------------------------------------------------------------------
   // Count qualification.
   // tX_cnt_sig is the valid of the datapath transfer: in a cycle where it is high the
   // controller consumes tX_th_nxt / tX_tl_nxt / tX_t_o at the closing edge. There is no
   // ready; the datapath is combinational and always accepts.
   // ---------------------------------------------------------------------------------
   assign run0 = tr0 & (~tmod[3] | sync2[2]);
   assign run1 = tr1 & (~tmod[7] | sync2[3]) & (tmod[5:4] != 2'b11);

   assign t0_cnt_sig = run0 & tick & (tmod[2] ? pend[0] : 1'b1);
   assign t1_cnt_sig = run1 & tick & (tmod[6] ? pend[1] : 1'b1);

   assign t0_t_s  = tmod[2];
   assign t1_t_s  = tmod[6];
   assign t0_tmod = tmod[3:0];
   assign t1_tmod = tmod[7:4];
   assign t0_th   = th0;
   assign t0_tl   = tl0;
   assign t1_th   = th1;
   assign t1_tl   = tl1;

   // ---------------------------------------------------------------------------------
   // SFR write decode
   // ---------------------------------------------------------------------------------
   assign wr_tcon = sfr_we && (sfr_addr == ADDR_TCON);
   assign wr_tmod = sfr_we && (sfr_addr == ADDR_TMOD);
   assign wr_tl0  = sfr_we && (sfr_addr == ADDR_TL0);
   assign wr_tl1  = sfr_we && (sfr_addr == ADDR_TL1);
   assign wr_th0  = sfr_we && (sfr_addr == ADDR_TH0);
   assign wr_th1  = sfr_we && (sfr_addr == ADDR_TH1);

   always_ff @(posedge clk) begin
      if (rst) begin
         tmod <= 8'h00;
      end else if (wr_tmod) begin
         tmod <= sfr_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tr0 <= 1'b0;
         tr1 <= 1'b0;
      end else if (wr_tcon) begin
         tr0 <= sfr_wdata[4];
         tr1 <= sfr_wdata[6];
      end
   end

   // ---------------------------------------------------------------------------------
   // Count registers: SFR write beats datapath write-back beats hold
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tl0 <= 8'h00;
      end else if (wr_tl0) begin
         tl0 <= sfr_wdata;
      end else if (t0_cnt_sig) begin
         tl0 <= t0_tl_nxt;
      end
   end

   // In mode 3 only the TL0 half runs, so TH0 ignores the write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         th0 <= 8'h00;
      end else if (wr_th0) begin
         th0 <= sfr_wdata;
      end else if (t0_cnt_sig && (tmod[1:0] != 2'b11)) begin
         th0 <= t0_th_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tl1 <= 8'h00;
      end else if (wr_tl1) begin
         tl1 <= sfr_wdata;
      end else if (t1_cnt_sig) begin
         tl1 <= t1_tl_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         th1 <= 8'h00;
      end else if (wr_th1) begin
         th1 <= sfr_wdata;
      end else if (t1_cnt_sig) begin
         th1 <= t1_th_nxt;
      end
   end

   // ---------------------------------------------------------------------------------
   // Overflow flags: a hardware set outranks an acknowledge so no overflow is lost.
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tf0 <= 1'b0;
      end else if (wr_tcon) begin
         tf0 <= sfr_wdata[5];
      end else if (t0_cnt_sig && t0_t_o) begin
         tf0 <= 1'b1;
      end else if (tf0_clr) begin
         tf0 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tf1 <= 1'b0;
      end else if (wr_tcon) begin
         tf1 <= sfr_wdata[7];
      end else if (t1_cnt_sig && t1_t_o) begin
         tf1 <= 1'b1;
      end else if (tf1_clr) begin
         tf1 <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------------
   // SFR read mux; TCON's interrupt half lives elsewhere and reads as zero here.
   // ---------------------------------------------------------------------------------
   always_comb begin
      sfr_rdata = 8'h00;
      case (sfr_addr)
         ADDR_TCON: sfr_rdata = {tf1, tr1, tf0, tr0, 4'h0};
         ADDR_TMOD: sfr_rdata = tmod;
         ADDR_TL0:  sfr_rdata = tl0;
         ADDR_TL1:  sfr_rdata = tl1;
         ADDR_TH0:  sfr_rdata = th0;
         ADDR_TH1:  sfr_rdata = th1;
         default:   sfr_rdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a small combinational datapath model and a
// queue-based scoreboard that compares whenever a check request is presented.
module tb_timer_ctrl;

   localparam int MC = 12;

   // ---------------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] sfr_addr  = 8'h00;
   logic       sfr_we    = 1'b0;
   logic [7:0] sfr_wdata = 8'h00;
   logic [7:0] sfr_rdata;
   logic       t0_pin = 1'b1;
   logic       t1_pin = 1'b1;
   logic       int0_n = 1'b1;
   logic       int1_n = 1'b1;
   logic       tf0_clr = 1'b0;
   logic       tf1_clr = 1'b0;
   logic       tf0;
   logic       tf1;
   logic       t0_cnt_sig, t1_cnt_sig;
   logic       t0_t_s, t1_t_s;
   logic [3:0] t0_tmod, t1_tmod;
   logic [7:0] t0_th, t0_tl, t1_th, t1_tl;
   logic [7:0] t0_th_nxt, t0_tl_nxt, t1_th_nxt, t1_tl_nxt;
   logic       t0_t_o, t1_t_o;

   timer_ctrl #(.CLK_PER_MC(MC)) dut (
      .clk(clk), .rst(rst),
      .sfr_addr(sfr_addr), .sfr_we(sfr_we), .sfr_wdata(sfr_wdata), .sfr_rdata(sfr_rdata),
      .t0_pin(t0_pin), .t1_pin(t1_pin), .int0_n(int0_n), .int1_n(int1_n),
      .tf0_clr(tf0_clr), .tf1_clr(tf1_clr), .tf0(tf0), .tf1(tf1),
      .t0_cnt_sig(t0_cnt_sig), .t0_t_s(t0_t_s), .t0_tmod(t0_tmod), .t0_th(t0_th), .t0_tl(t0_tl),
      .t0_th_nxt(t0_th_nxt), .t0_tl_nxt(t0_tl_nxt), .t0_t_o(t0_t_o),
      .t1_cnt_sig(t1_cnt_sig), .t1_t_s(t1_t_s), .t1_tmod(t1_tmod), .t1_th(t1_th), .t1_tl(t1_tl),
      .t1_th_nxt(t1_th_nxt), .t1_tl_nxt(t1_tl_nxt), .t1_t_o(t1_t_o)
   );

   // ---------------------------------------------------------------------------------
   // Datapath model: returns {overflow, th_next, tl_next}
   // ---------------------------------------------------------------------------------
   function automatic logic [16:0] dp(input logic [3:0] md, input logic [7:0] th,
                                      input logic [7:0] tl, input logic is_t1);
      logic [12:0] v13;
      logic [15:0] v16;
      logic [16:0] r;
      v13 = '0;
      v16 = '0;
      r   = {1'b0, th, tl};
      case (md[1:0])
         2'd0: begin
            v13 = {th, tl[4:0]} + 13'd1;
            r   = {&{th, tl[4:0]}, v13[12:5], tl[7:5], v13[4:0]};
         end
         2'd1: begin
            v16 = {th, tl} + 16'd1;
            r   = {&{th, tl}, v16};
         end
         2'd2:    r = {&tl, th, (&tl) ? th : tl + 8'd1};
         default: if (!is_t1) r = {&tl, th, tl + 8'd1};
      endcase
      return r;
   endfunction

   always_comb begin
      {t0_t_o, t0_th_nxt, t0_tl_nxt} = dp(t0_tmod, t0_th, t0_tl, 1'b0);
      {t1_t_o, t1_th_nxt, t1_tl_nxt} = dp(t1_tmod, t1_th, t1_tl, 1'b1);
   end

   // ---------------------------------------------------------------------------------
   // Cycle counter since reset release and first-count observation
   // ---------------------------------------------------------------------------------
   int cyc = 0;
   int first_tick = 0;

   always @(negedge clk) begin
      if (rst) begin
         cyc        = 0;
         first_tick = 0;
      end else begin
         cyc = cyc + 1;
         if (t0_cnt_sig && first_tick == 0) first_tick = cyc;
      end
   end

   // ---------------------------------------------------------------------------------
   // Scoreboard: entry = {kind[1:0], value[7:0]}; kind 0 rdata, 1 tf0, 2 tf1, 3 first tick
   // ---------------------------------------------------------------------------------
   logic [9:0] exp_q[$];
   string      name_q[$];
   logic       mon_req = 1'b0;
   int         n_pass  = 0;
   int         n_total = 0;

   always @(negedge clk) begin
      logic [9:0] e;
      string      nm;
      logic [7:0] act;
      if (mon_req) begin
         n_total = n_total + 1;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: check presented, got empty queue required an entry");
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (e[9:8])
               2'd0:    act = sfr_rdata;
               2'd1:    act = {7'b0, tf0};
               2'd2:    act = {7'b0, tf1};
               default: act = first_tick[7:0];
            endcase
            if (act == e[7:0]) n_pass = n_pass + 1;
            else $display("FAIL %s: got 0x%02h required 0x%02h", nm, act, e[7:0]);
         end
      end
   end

   // ---------------------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
      sfr_addr  = a;
      sfr_wdata = d;
      sfr_we    = 1'b1;
      step();
      sfr_we    = 1'b0;
   endtask

   task automatic expect_val(input logic [1:0] kind, input logic [7:0] v, input string nm);
      exp_q.push_back({kind, v});
      name_q.push_back(nm);
   endtask

   task automatic check_rd(input logic [7:0] a, input logic [7:0] v, input string nm);
      sfr_addr = a;
      expect_val(2'd0, v, nm);
      mon_req = 1'b1;
      step();
      mon_req = 1'b0;
   endtask

   task automatic check_obs(input logic [1:0] kind, input logic [7:0] v, input string nm);
      expect_val(kind, v, nm);
      mon_req = 1'b1;
      step();
      mon_req = 1'b0;
   endtask

   // Leaves the bench in the cycle right after the n-th upcoming tick cycle.
   task automatic wait_tick(input int n);
      for (int i = 0; i < n; i++) begin
         int k;
         k = 0;
         do begin
            @(negedge clk);
            #1;
            k++;
         end while ((cyc % MC) != 0 && k < 100);
      end
      step();
   endtask

   task automatic wait_to_cycle(input int c);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (cyc != c - 1 && k < 200);
      step();
   endtask

   // ---------------------------------------------------------------------------------
   // Directed tests
   // ---------------------------------------------------------------------------------
   initial begin
      step();

      // Reset state
      do_reset();
      check_rd(8'h88, 8'h00, "rst_tcon");
      check_rd(8'h89, 8'h00, "rst_tmod");
      check_rd(8'h8A, 8'h00, "rst_tl0");
      check_rd(8'h8B, 8'h00, "rst_tl1");
      check_rd(8'h8C, 8'h00, "rst_th0");
      check_rd(8'h8D, 8'h00, "rst_th1");
      check_obs(2'd1, 8'h00, "rst_tf0");
      check_obs(2'd2, 8'h00, "rst_tf1");
      check_rd(8'h90, 8'h00, "unmapped_addr");

      // Mode 1 overflow and acknowledge
      do_reset();
      sfr_write(8'h89, 8'h01);
      sfr_write(8'h8C, 8'hFF);
      sfr_write(8'h8A, 8'hFE);
      sfr_write(8'h88, 8'h10);
      wait_tick(1);
      check_rd(8'h8A, 8'hFF, "m1_tl0_tick1");
      wait_tick(1);
      check_rd(8'h8C, 8'h00, "m1_th0_wrap");
      check_rd(8'h8A, 8'h00, "m1_tl0_wrap");
      check_obs(2'd1, 8'h01, "m1_tf0_set");
      check_rd(8'h88, 8'h30, "m1_tcon_tf0");
      tf0_clr = 1'b1;
      step();
      tf0_clr = 1'b0;
      check_obs(2'd1, 8'h00, "m1_tf0_ack");
      check_rd(8'h88, 8'h10, "m1_tcon_ack");

      // Mode 2 auto-reload on Timer 1
      do_reset();
      sfr_write(8'h89, 8'h20);
      sfr_write(8'h8D, 8'hF0);
      sfr_write(8'h8B, 8'hFE);
      sfr_write(8'h88, 8'h40);
      wait_tick(2);
      check_rd(8'h8B, 8'hF0, "m2_tl1_reload");
      check_rd(8'h8D, 8'hF0, "m2_th1_kept");
      check_obs(2'd2, 8'h01, "m2_tf1_set");
      check_rd(8'h88, 8'hC0, "m2_tcon");

      // GATE: counting only while INT0 is high
      int0_n = 1'b0;
      do_reset();
      sfr_write(8'h89, 8'h09);
      sfr_write(8'h88, 8'h10);
      wait_tick(5);
      check_rd(8'h8A, 8'h00, "gate_blocked");
      int0_n = 1'b1;
      wait_tick(3);
      check_rd(8'h8A, 8'h03, "gate_open_tl0");
      check_rd(8'h8C, 8'h00, "gate_open_th0");

      // Counter mode: three spaced edges plus two edges in one machine cycle
      do_reset();
      sfr_write(8'h89, 8'h05);
      sfr_write(8'h88, 8'h10);
      for (int i = 0; i < 3; i++) begin
         t0_pin = 1'b0;
         repeat (5) step();
         t0_pin = 1'b1;
         repeat (25) step();
      end
      wait_tick(1);
      t0_pin = 1'b0;
      step();
      t0_pin = 1'b1;
      step();
      t0_pin = 1'b0;
      step();
      t0_pin = 1'b1;
      wait_tick(2);
      check_rd(8'h8A, 8'h04, "cnt_tl0");
      check_rd(8'h8C, 8'h00, "cnt_th0");

      // Collisions: SFR write beats count; overflow beats acknowledge
      do_reset();
      sfr_write(8'h89, 8'h01);
      sfr_write(8'h88, 8'h10);
      wait_to_cycle(24);
      sfr_write(8'h8A, 8'h55);
      check_rd(8'h8A, 8'h55, "col_wr_tl0");
      check_rd(8'h8C, 8'h00, "col_wr_th0");
      sfr_write(8'h8C, 8'hFF);
      sfr_write(8'h8A, 8'hFF);
      wait_to_cycle(36);
      tf0_clr = 1'b1;
      step();
      tf0_clr = 1'b0;
      check_obs(2'd1, 8'h01, "col_tf0_vs_clr");
      check_rd(8'h8A, 8'h00, "col_ovf_tl0");
      check_rd(8'h8C, 8'h00, "col_ovf_th0");

      // Reset in the middle of counting
      do_reset();
      sfr_write(8'h89, 8'h01);
      sfr_write(8'h8A, 8'h37);
      sfr_write(8'h88, 8'h10);
      wait_tick(1);
      check_rd(8'h8A, 8'h38, "mid_tl0_before");
      repeat (3) step();
      do_reset();
      sfr_addr  = 8'h88;
      sfr_wdata = 8'h10;
      sfr_we    = 1'b1;
      expect_val(2'd0, 8'h00, "mid_rst_tcon");
      mon_req = 1'b1;
      step();
      sfr_we  = 1'b0;
      mon_req = 1'b0;
      check_rd(8'h89, 8'h00, "mid_rst_tmod");
      check_rd(8'h8A, 8'h00, "mid_rst_tl0");
      check_rd(8'h8C, 8'h00, "mid_rst_th0");
      check_rd(8'h8B, 8'h00, "mid_rst_tl1");
      check_rd(8'h8D, 8'h00, "mid_rst_th1");
      check_obs(2'd1, 8'h00, "mid_rst_tf0");
      wait_tick(1);
      check_obs(2'd3, 8'd12, "mid_rst_first_tick");
      check_rd(8'h8A, 8'h01, "mid_rst_tl0_first");

      // Final report
      step();
      step();
      if (exp_q.size() != 0) begin
         n_total = n_total + 1;
         $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
